// File: rtl/mux_nto1_hs.sv
// mux_nto1_hs: N:1 stream multiplexer with a registered output stage.
//
// Purpose:
//   Funnels N valid/ready producers into one consumer. The grant is chosen
//   each cycle by an external select (mode=0) or by a round-robin arbiter
//   (mode=1). One output register with pass-through refill: a full register
//   that is drained in a cycle can be refilled in the same cycle.
//
// Handshake: a beat moves on a port when its valid and ready are both high at
//   a rising clk edge. in_ready never depends on in_data. out_valid,
//   out_data and out_sel come from flops.
//
// Ports:
//   clk, rst              rising-edge clock, synchronous active-high reset
//   mode                  0 = fixed select via s, 1 = round-robin
//   s [SEL_W]             channel select, used in fixed mode
//   in_data [N*W]         channel i at bits [i*W +: W]
//   in_valid/in_ready [N] per-channel handshake (in_ready combinational)
//   out_data [W]          registered data
//   out_valid/out_ready   output handshake
//   out_sel [SEL_W]       index of the channel that produced out_data
//
// Optional build macro MUX_XFER_CNT_EN adds:
//   xfer_cnt [16]  count of accepted input transfers (wraps)
//   err_sel  [1]   registered flag, high the cycle after mode=0 && s>=N
module mux_nto1_hs #(
  parameter int N     = 4,
  parameter int W     = 8,
  parameter int SEL_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mode,
  input  logic [SEL_W-1:0] s,
  input  logic [N*W-1:0]   in_data,
  input  logic [N-1:0]     in_valid,
  output logic [N-1:0]     in_ready,
  output logic [W-1:0]     out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [SEL_W-1:0] out_sel
`ifdef MUX_XFER_CNT_EN
  ,
  output logic [15:0]      xfer_cnt,
  output logic             err_sel
`endif
);

  logic [W-1:0]     out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic [SEL_W-1:0] out_sel_q, out_sel_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;

  logic [SEL_W-1:0] g;
  logic             grant_valid;
  logic             load_en;
  logic             xfer;
  int               idx;

  // Grant selection. In round-robin mode the scan runs from the highest
  // offset down so that the lowest offset from ptr (the first hit in
  // ptr, ptr+1, ... order) is the one that sticks.
  always_comb begin
    g           = '0;
    grant_valid = 1'b0;
    idx         = 0;
    if (mode) begin
      for (int k = N - 1; k >= 0; k--) begin
        idx = (int'(ptr_q) + k) % N;
        if (in_valid[idx]) begin
          grant_valid = 1'b1;
          g           = SEL_W'(idx);
        end
      end
    end else begin
      g = s;
      if (int'(s) < N) grant_valid = in_valid[s];
    end
  end

  assign load_en = !out_valid_q || out_ready;
  // rst gates the transfer so nothing is accepted in a reset cycle.
  assign xfer    = !rst && load_en && grant_valid;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      in_ready[i] = xfer && (int'(g) == i);
    end
  end

  always_comb begin
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    out_valid_d = out_valid_q;
    ptr_d       = ptr_q;
    if (xfer) begin
      out_data_d  = in_data[int'(g)*W +: W];
      out_sel_d   = g;
      out_valid_d = 1'b1;
      if (mode) ptr_d = (int'(g) == N - 1) ? '0 : g + 1'b1;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_data_q  <= '0;
      out_sel_q   <= '0;
      out_valid_q <= 1'b0;
      ptr_q       <= '0;
    end else begin
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
      out_valid_q <= out_valid_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;
  assign out_valid = out_valid_q;

`ifdef MUX_XFER_CNT_EN
  logic [15:0] xfer_cnt_q, xfer_cnt_d;
  logic        err_sel_q, err_sel_d;

  always_comb begin
    xfer_cnt_d = xfer ? xfer_cnt_q + 16'd1 : xfer_cnt_q;
    err_sel_d  = !mode && (int'(s) >= N);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      xfer_cnt_q <= '0;
      err_sel_q  <= 1'b0;
    end else begin
      xfer_cnt_q <= xfer_cnt_d;
      err_sel_q  <= err_sel_d;
    end
  end

  assign xfer_cnt = xfer_cnt_q;
  assign err_sel  = err_sel_q;
`endif

endmodule

// File: tb/tb_mux_nto1_hs.sv
// Testbench for mux_nto1_hs: a 4-channel instance carries the main directed
// sequence with a scoreboard queue; a 3-channel instance covers out-of-range
// select. Build with +define+MUX_XFER_CNT_EN to also check xfer_cnt/err_sel.
module tb_mux_nto1_hs;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // ---------------- DUT, N=4 ----------------
  logic        mode4;
  logic [1:0]  s4;
  logic [31:0] in_data4;
  logic [3:0]  in_valid4, in_ready4;
  logic [7:0]  out_data4;
  logic        out_valid4, out_ready4;
  logic [1:0]  out_sel4;
`ifdef MUX_XFER_CNT_EN
  logic [15:0] xfer_cnt4;
  logic        err_sel4;
`endif

  mux_nto1_hs #(.N(4), .W(8)) dut4 (
    .clk(clk), .rst(rst), .mode(mode4), .s(s4),
    .in_data(in_data4), .in_valid(in_valid4), .in_ready(in_ready4),
    .out_data(out_data4), .out_valid(out_valid4), .out_ready(out_ready4),
    .out_sel(out_sel4)
`ifdef MUX_XFER_CNT_EN
    , .xfer_cnt(xfer_cnt4), .err_sel(err_sel4)
`endif
  );

  // ---------------- DUT, N=3 ----------------
  logic        mode3;
  logic [1:0]  s3;
  logic [23:0] in_data3;
  logic [2:0]  in_valid3, in_ready3;
  logic [7:0]  out_data3;
  logic        out_valid3, out_ready3;
  logic [1:0]  out_sel3;
`ifdef MUX_XFER_CNT_EN
  logic [15:0] xfer_cnt3;
  logic        err_sel3;
`endif

  mux_nto1_hs #(.N(3), .W(8)) dut3 (
    .clk(clk), .rst(rst), .mode(mode3), .s(s3),
    .in_data(in_data3), .in_valid(in_valid3), .in_ready(in_ready3),
    .out_data(out_data3), .out_valid(out_valid3), .out_ready(out_ready3),
    .out_sel(out_sel3)
`ifdef MUX_XFER_CNT_EN
    , .xfer_cnt(xfer_cnt3), .err_sel(err_sel3)
`endif
  );

  // ---------------- scoreboard ----------------
  logic [9:0] exp_q[$];   // {sel, data}
  int n_cmp = 0;
  int n_err = 0;
  int n_xfer4 = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: each output beat is compared once, in the cycle it is consumed.
  always @(negedge clk) begin
    if (!rst && out_valid4 && out_ready4) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL out_beat: got %0h expected none", {out_sel4, out_data4});
      end else begin
        chk("out_beat", {22'd0, out_sel4, out_data4}, {22'd0, exp_q.pop_front()});
      end
    end
  end

  // ---------------- driver ----------------
  // Called at posedge+1. Drives one cycle, checks in_ready mid-cycle and,
  // when a transfer is expected, records the beat the DUT must later emit.
  task automatic step(input logic m, input logic [1:0] sel, input logic [3:0] v,
                      input logic ordy, input logic [3:0] exp_rdy, input logic push_en);
    int gi;
    mode4 = m; s4 = sel; in_valid4 = v; out_ready4 = ordy;
    @(negedge clk);
    chk("in_ready4", {28'd0, in_ready4}, {28'd0, exp_rdy});
    if (exp_rdy != 4'b0000) begin
      gi = 0;
      for (int i = 0; i < 4; i++) if (exp_rdy[i]) gi = i;
      n_xfer4++;
      if (push_en) exp_q.push_back({2'(gi), in_data4[gi*8 +: 8]});
    end
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1;
    mode4 = 1'b0; s4 = 2'd0; in_data4 = 32'h44332211; in_valid4 = 4'hF; out_ready4 = 1'b1;
    mode3 = 1'b0; s3 = 2'd0; in_data3 = 24'h332211;   in_valid3 = 3'h7; out_ready3 = 1'b1;

    // Reset with every channel requesting.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", {31'd0, out_valid4}, 32'd0);
    chk("rst_out_data", {24'd0, out_data4}, 32'd0);
    chk("rst_out_sel", {30'd0, out_sel4}, 32'd0);
    chk("rst_in_ready", {28'd0, in_ready4}, 32'd0);
    chk("rst_in_ready3", {29'd0, in_ready3}, 32'd0);
    rst = 1'b0; in_valid4 = 4'h0; in_valid3 = 3'h0;
    @(posedge clk); #1;

    // Fixed select s=2.
    step(1'b0, 2'd2, 4'b1111, 1'b1, 4'b0100, 1'b1);

    // Round-robin fairness, all requesting, one beat per cycle.
    for (int i = 0; i < 8; i++) step(1'b1, 2'd0, 4'b1111, 1'b1, 4'(1 << (i % 4)), 1'b1);

    // Round-robin skip: move ptr to 1, then alternate 3,0,3.
    step(1'b1, 2'd0, 4'b0001, 1'b1, 4'b0001, 1'b1);
    step(1'b1, 2'd0, 4'b1001, 1'b1, 4'b1000, 1'b1);
    step(1'b1, 2'd0, 4'b1001, 1'b1, 4'b0001, 1'b1);
    step(1'b1, 2'd0, 4'b1001, 1'b1, 4'b1000, 1'b1);

    // Backpressure: register holds {3,44}.
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 2'd0, 4'b1111, 1'b0, 4'b0000, 1'b1);
      chk("bp_out_data", {24'd0, out_data4}, 32'h44);
      chk("bp_out_valid", {31'd0, out_valid4}, 32'd1);
    end
    // Release: drain and refill in the same cycle (ptr=0 after grant 3).
    step(1'b1, 2'd0, 4'b1111, 1'b1, 4'b0001, 1'b1);
    chk("refill_data", {24'd0, out_data4}, 32'h11);
    step(1'b1, 2'd0, 4'b0000, 1'b1, 4'b0000, 1'b1);
    chk("drained_valid", {31'd0, out_valid4}, 32'd0);

    // Fixed mode with new data; unrequested select gives no grant.
    in_data4 = 32'hA4A3A2A1;
    step(1'b0, 2'd1, 4'b0010, 1'b1, 4'b0010, 1'b1);
    step(1'b0, 2'd0, 4'b1110, 1'b1, 4'b0000, 1'b1);
    // ptr (1) survived fixed mode: channel 1 wins over channel 0.
    step(1'b1, 2'd0, 4'b0011, 1'b1, 4'b0010, 1'b1);
    step(1'b1, 2'd0, 4'b0000, 1'b1, 4'b0000, 1'b1);

    // Reset mid-stream: pending beat is dropped, no transfer while rst=1.
    step(1'b0, 2'd0, 4'b0001, 1'b0, 4'b0001, 1'b0);
    rst = 1'b1; in_valid4 = 4'hF;
    @(negedge clk);
    chk("midrst_in_ready", {28'd0, in_ready4}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; n_xfer4 = 0;
    chk("midrst_out_valid", {31'd0, out_valid4}, 32'd0);
    step(1'b1, 2'd0, 4'b1111, 1'b1, 4'b0001, 1'b1);
    step(1'b1, 2'd0, 4'b0000, 1'b1, 4'b0000, 1'b1);
    chk("queue_empty", exp_q.size(), 32'd0);
`ifdef MUX_XFER_CNT_EN
    chk("xfer_cnt4", {16'd0, xfer_cnt4}, n_xfer4);
    chk("err_sel4", {31'd0, err_sel4}, 32'd0);
`endif

    // N=3: s=3 is out of range.
    mode3 = 1'b0; s3 = 2'd3; in_valid3 = 3'b111; out_ready3 = 1'b1;
    @(negedge clk);
    chk("badsel_in_ready3", {29'd0, in_ready3}, 32'd0);
    @(posedge clk); #1;
    chk("badsel_out_valid3", {31'd0, out_valid3}, 32'd0);
`ifdef MUX_XFER_CNT_EN
    chk("err_sel3", {31'd0, err_sel3}, 32'd1);
    chk("xfer_cnt3_hold", {16'd0, xfer_cnt3}, 32'd0);
`endif
    s3 = 2'd2;
    @(negedge clk);
    chk("sel2_in_ready3", {29'd0, in_ready3}, 32'b100);
    @(posedge clk); #1;
    chk("sel2_out_valid3", {31'd0, out_valid3}, 32'd1);
    chk("sel2_out_data3", {24'd0, out_data3}, 32'h33);
    chk("sel2_out_sel3", {30'd0, out_sel3}, 32'd2);
`ifdef MUX_XFER_CNT_EN
    chk("err_sel3_clr", {31'd0, err_sel3}, 32'd0);
    chk("xfer_cnt3_inc", {16'd0, xfer_cnt3}, 32'd1);
`endif
    in_valid3 = 3'b000;
    repeat (2) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
